pcie_lane_striper: RTL and testbench
====================================

PCIE_LANE_STRIPER -- requirements
Module: pcie_lane_striper

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, symbol width in bits.
REQ-002 SHALL provide parameter LANES, default 4, physical lane count; legal values 1, 2, 4, 8.
REQ-003 SHALL provide parameter PAD_SYM, default 8'hF7, fill symbol for short final stripe.
REQ-004 SHALL provide parameter IDL_SYM, default 8'h7C, symbol driven on inactive lanes.
REQ-005 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port link_width  input  2  requested width: 0=x1, 1=x2, 2=x4, 3=x8.
REQ-008 SHALL have port in_data  input  DATA_W  byte from multiplexer stage.
REQ-009 SHALL have port in_vld  input  1  in_data valid.
REQ-010 SHALL have port in_end  input  1  marks in_data as last byte of packet.
REQ-011 SHALL have port in_rdy  output  1  striper accepts in_data this cycle.
REQ-012 SHALL have port out_lanes  output  LANES*DATA_W  striped word, lane0 in LSBs.
REQ-013 SHALL have port out_lane_en  output  LANES  one bit per lane carrying stripe data.
REQ-014 SHALL have port out_vld  output  1  out_lanes/out_lane_en valid.
REQ-015 SHALL have port out_rdy  input  1  downstream (p2s stage) consumes word.

Function
REQ-016 Active width W SHALL be min(2^link_width, LANES); link_width above the LANES limit clamps to LANES.
REQ-017 W SHALL be sampled into an internal register only when the accumulator is empty (lane index 0, no pending stripe); link_width changes mid-stripe SHALL take effect at the next stripe boundary.
REQ-018 A byte SHALL be accepted on an edge where in_vld and in_rdy are both 1; otherwise in_data/in_end SHALL be ignored.
REQ-019 Accepted bytes SHALL fill accumulator lanes in order 0,1,...,W-1 via a lane index counter that wraps to 0 after lane W-1.
REQ-020 A stripe SHALL complete when the byte for lane W-1 is accepted, or when a byte with in_end=1 is accepted at any index.
REQ-021 On in_end completion at index k<W-1, lanes k+1..W-1 SHALL be filled with PAD_SYM and the index SHALL return to 0.
REQ-022 In every emitted word, lanes W..LANES-1 SHALL carry IDL_SYM and out_lane_en SHALL equal (2^W)-1.
REQ-023 Output SHALL be a single holding register; a completed stripe SHALL load it on the completing edge if it is empty or being consumed (out_vld&out_rdy) that edge: latency last-byte-accept edge -> out_vld=1 is one edge.
REQ-024 If the holding register is full and not draining, the completed stripe SHALL be parked (acc_full=1) and move to the holding register on the first edge with out_rdy=1.
REQ-025 in_rdy SHALL equal !acc_full (combinational from registered state, no dependence on in_vld).
REQ-026 While out_vld=1 and out_rdy=0, out_lanes and out_lane_en SHALL hold stable.
REQ-027 out_vld SHALL clear on a consuming edge unless a new stripe loads that same edge, giving one word per cycle at full throughput.
REQ-028 For W=1 every accepted byte SHALL complete a stripe; in_end SHALL cause no padding.
REQ-029 in_end with in_vld=0 SHALL have no effect.

Reset
REQ-030 While reset=0: out_vld=0, out_lane_en=0, out_lanes=all IDL_SYM, acc_full=0, lane index=0, in_rdy=1, W register=min(2^link_width, LANES) sampled at the first edge after release.
REQ-031 Reset asserted mid-stripe SHALL discard the partial stripe and any held word with no PAD emission.

Verification
REQ-032 LANES=4, link_width=2, bytes 01,02,03,04 back-to-back, out_rdy=1 -> one edge after 04: out_lanes=32'h04030201, out_lane_en=4'hF, out_vld one cycle.
REQ-033 link_width=2, bytes AA,BB with in_end on BB -> out_lanes=32'hF7F7BBAA, out_lane_en=4'hF.
REQ-034 link_width=1, bytes 11,22,33,44 -> words 32'h7C7C2211 then 32'h7C7C4433, out_lane_en=4'h3.
REQ-035 link_width=2, out_rdy=0, 8 bytes offered -> first word held stable, second parked, in_rdy=0 after 8th byte; out_rdy=1 -> both words delivered on consecutive cycles, then in_rdy=1.
REQ-036 link_width changed 2->0 after 2 of 4 bytes -> current stripe completes as x4; following bytes emitted one per word with out_lane_en=4'h1.
REQ-037 reset pulled low after 3 bytes -> out_vld=0, out_lanes=32'h7C7C7C7C immediately; after release, 4 new bytes produce a clean word with no remnant bytes.

Source files
------------

// File: rtl/pcie_lane_striper.sv
// ---------------------------------------------------------------------------
// pcie_lane_striper
//
// Purpose:
//   Spreads a byte stream across LANES physical lanes. The active width is
//   W = min(2^link_width, LANES). Incoming bytes fill lanes 0..W-1 in order.
//   A stripe is complete when lane W-1 is filled or when a byte marked
//   in_end is accepted. When in_end arrives early, the remaining active
//   lanes are filled with PAD_SYM. Lanes at or above W always carry IDL_SYM.
//   Each completed stripe goes into a single output holding register. If
//   that register is occupied and not draining, the completed stripe waits
//   in a parking slot (acc_full). While a stripe is parked, input is stalled.
//
// Ports:
//   CLK          in   sole clock, rising edge
//   reset        in   asynchronous, active-low reset
//   link_width   in   requested width code: 0=x1, 1=x2, 2=x4, 3=x8
//   in_data      in   byte from the multiplexer stage
//   in_vld       in   in_data valid
//   in_end       in   in_data is the last byte of a packet
//   in_rdy       out  striper can accept in_data this cycle
//   out_lanes    out  striped word, lane 0 in the LSBs
//   out_lane_en  out  one bit per lane carrying stripe data
//   out_vld      out  out_lanes / out_lane_en valid
//   out_rdy      in   downstream consumes the word this cycle
// ---------------------------------------------------------------------------
module pcie_lane_striper #(
    parameter int                DATA_W  = 8,
    parameter int                LANES   = 4,
    parameter logic [DATA_W-1:0] PAD_SYM = 8'hF7,
    parameter logic [DATA_W-1:0] IDL_SYM = 8'h7C
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [1:0]              link_width,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_vld,
    input  logic                    in_end,
    output logic                    in_rdy,
    output logic [LANES*DATA_W-1:0] out_lanes,
    output logic [LANES-1:0]        out_lane_en,
    output logic                    out_vld,
    input  logic                    out_rdy
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WW = 4;                 // holds a lane count up to 8
    localparam int OW = LANES * DATA_W;

    logic [WW-1:0]    w_q, w_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             acc_full_q, acc_full_d;
    logic [OW-1:0]    acc_q, acc_d;
    logic [LANES-1:0] park_en_q, park_en_d;
    logic [OW-1:0]    hold_q, hold_d;
    logic [LANES-1:0] hold_en_q, hold_en_d;
    logic             out_vld_q, out_vld_d;

    logic [WW-1:0]    w_in;
    logic [WW-1:0]    w_eff;
    logic             acc_empty;
    logic             accept;
    logic             last;
    logic             hold_free;
    logic [OW-1:0]    stripe_word;
    logic [LANES-1:0] stripe_en;

    // Lane-enable mask for a width of w lanes.
    function automatic logic [LANES-1:0] lane_mask(input logic [WW-1:0] w);
        logic [LANES-1:0] m;
        for (int l = 0; l < LANES; l++) begin
            m[l] = (l < int'(w));
        end
        return m;
    endfunction

    // Requested width, clamped to the physical lane count.
    always_comb begin
        w_in = WW'(LANES);
        case (link_width)
            2'd0:    w_in = WW'(1);
            2'd1:    w_in = WW'(2);
            2'd2:    w_in = WW'(4);
            default: w_in = WW'(8);
        endcase
        if (w_in > WW'(LANES)) begin
            w_in = WW'(LANES);
        end
    end

    // The width is only re-sampled at a stripe boundary. The first byte of a
    // stripe already uses the newly requested width, so a mid-stripe change
    // applies from the next stripe onward.
    assign acc_empty = (idx_q == '0) && !acc_full_q;
    assign w_eff     = acc_empty ? w_in : w_q;

    assign in_rdy    = !acc_full_q;
    assign accept    = in_vld && !acc_full_q;
    assign last      = in_end || (WW'(idx_q) == (w_eff - WW'(1)));
    assign hold_free = !out_vld_q || out_rdy;

    // Completed stripe as it would look if this byte finishes it.
    // Lanes before idx come from the accumulator, idx gets the new byte,
    // lanes after idx get padding, and lanes above the width are idle.
    always_comb begin
        stripe_word = '0;
        for (int l = 0; l < LANES; l++) begin
            if (l >= int'(w_eff)) begin
                stripe_word[l*DATA_W +: DATA_W] = IDL_SYM;
            end else if (l < int'(idx_q)) begin
                stripe_word[l*DATA_W +: DATA_W] = acc_q[l*DATA_W +: DATA_W];
            end else if (l == int'(idx_q)) begin
                stripe_word[l*DATA_W +: DATA_W] = in_data;
            end else begin
                stripe_word[l*DATA_W +: DATA_W] = PAD_SYM;
            end
        end
        stripe_en = lane_mask(w_eff);
    end

    // Next-state logic for the accumulator, parking slot and holding register.
    always_comb begin
        w_d        = w_q;
        idx_d      = idx_q;
        acc_full_d = acc_full_q;
        acc_d      = acc_q;
        park_en_d  = park_en_q;
        hold_d     = hold_q;
        hold_en_d  = hold_en_q;
        out_vld_d  = out_vld_q;

        if (acc_empty) begin
            w_d = w_in;
        end

        if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
        end

        if (acc_full_q) begin
            // A stripe is parked only while the holding register is full, so
            // the first out_rdy both drains the old word and loads this one.
            if (out_rdy) begin
                hold_d     = acc_q;
                hold_en_d  = park_en_q;
                out_vld_d  = 1'b1;
                acc_full_d = 1'b0;
            end
        end else if (accept) begin
            if (last) begin
                idx_d = '0;
                if (hold_free) begin
                    hold_d    = stripe_word;
                    hold_en_d = stripe_en;
                    out_vld_d = 1'b1;
                end else begin
                    acc_d      = stripe_word;
                    park_en_d  = stripe_en;
                    acc_full_d = 1'b1;
                end
            end else begin
                acc_d[idx_q*DATA_W +: DATA_W] = in_data;
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Register stage: the accumulator, parking slot and output holding
    // register all update on the same edge.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            w_q        <= WW'(LANES);
            idx_q      <= '0;
            acc_full_q <= 1'b0;
            acc_q      <= {LANES{IDL_SYM}};
            park_en_q  <= '0;
            hold_q     <= {LANES{IDL_SYM}};
            hold_en_q  <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            w_q        <= w_d;
            idx_q      <= idx_d;
            acc_full_q <= acc_full_d;
            acc_q      <= acc_d;
            park_en_q  <= park_en_d;
            hold_q     <= hold_d;
            hold_en_q  <= hold_en_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign out_lanes   = hold_q;
    assign out_lane_en = hold_en_q;
    assign out_vld     = out_vld_q;

endmodule

// File: tb/tb_pcie_lane_striper.sv
module tb_pcie_lane_striper;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  link_width = 2'd2;
    logic [7:0]  in_data = 8'h00;
    logic        in_vld = 1'b0;
    logic        in_end = 1'b0;
    logic        in_rdy;
    logic [31:0] out_lanes;
    logic [3:0]  out_lane_en;
    logic        out_vld;
    logic        out_rdy = 1'b1;

    int errors = 0;
    int checks = 0;

    pcie_lane_striper #(
        .DATA_W (8),
        .LANES  (4),
        .PAD_SYM(8'hF7),
        .IDL_SYM(8'h7C)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .link_width (link_width),
        .in_data    (in_data),
        .in_vld     (in_vld),
        .in_end     (in_end),
        .in_rdy     (in_rdy),
        .out_lanes  (out_lanes),
        .out_lane_en(out_lane_en),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  lw;
        logic        vld;
        logic [7:0]  d;
        logic        e;
        logic        ordy;
        logic        xv;
        logic [31:0] xl;
        logic [3:0]  xe;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] lw, input logic vld, input logic [7:0] d,
                                input logic e, input logic xv, input logic [31:0] xl,
                                input logic [3:0] xe);
        vec_t v;
        v.lw = lw; v.vld = vld; v.d = d; v.e = e; v.ordy = 1'b1;
        v.xv = xv; v.xl = xl; v.xe = xe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample 1ns after the rising edge.
    task automatic cyc(input logic [1:0] lw, input logic vld, input logic [7:0] d,
                       input logic e, input logic ordy);
        @(negedge CLK);
        link_width = lw; in_vld = vld; in_data = d; in_end = e; out_rdy = ordy;
        @(posedge CLK);
        #1;
    endtask

    vec_t tv[$];

    initial begin
        // Table of per-cycle vectors; expected values are computed by hand.
        tv.push_back(mk(2'd2, 1, 8'h01, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd2, 1, 8'h02, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd2, 1, 8'h03, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd2, 1, 8'h04, 0, 1, 32'h04030201, 4'hF));
        tv.push_back(mk(2'd2, 0, 8'h00, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd2, 1, 8'hAA, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd2, 1, 8'hBB, 1, 1, 32'hF7F7BBAA, 4'hF));
        tv.push_back(mk(2'd1, 1, 8'h11, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd1, 1, 8'h22, 0, 1, 32'h7C7C2211, 4'h3));
        tv.push_back(mk(2'd1, 1, 8'h33, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd1, 1, 8'h44, 0, 1, 32'h7C7C4433, 4'h3));
        tv.push_back(mk(2'd2, 1, 8'h55, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd2, 1, 8'h66, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd0, 1, 8'h77, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd0, 1, 8'h88, 0, 1, 32'h88776655, 4'hF));
        tv.push_back(mk(2'd0, 1, 8'h99, 0, 1, 32'h7C7C7C99, 4'h1));
        tv.push_back(mk(2'd0, 1, 8'hA1, 0, 1, 32'h7C7C7CA1, 4'h1));
        tv.push_back(mk(2'd0, 0, 8'h00, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd0, 1, 8'hB2, 1, 1, 32'h7C7C7CB2, 4'h1));
        tv.push_back(mk(2'd2, 0, 8'h00, 1, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd2, 1, 8'hC1, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd2, 0, 8'hEE, 1, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd2, 1, 8'hC2, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd2, 1, 8'hC3, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd2, 1, 8'hC4, 0, 1, 32'hC4C3C2C1, 4'hF));
        tv.push_back(mk(2'd3, 1, 8'hD1, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd3, 1, 8'hD2, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd3, 1, 8'hD3, 0, 0, 32'h0, 4'h0));
        tv.push_back(mk(2'd3, 1, 8'hD4, 0, 1, 32'hD4D3D2D1, 4'hF));

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_out_vld", {31'b0, out_vld}, 32'h0);
        chk("rst_out_lanes", out_lanes, 32'h7C7C7C7C);
        chk("rst_out_lane_en", {28'b0, out_lane_en}, 32'h0);
        chk("rst_in_rdy", {31'b0, in_rdy}, 32'h1);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;

        // Table-driven vectors
        foreach (tv[i]) begin
            cyc(tv[i].lw, tv[i].vld, tv[i].d, tv[i].e, tv[i].ordy);
            chk($sformatf("vec%0d_out_vld", i), {31'b0, out_vld}, {31'b0, tv[i].xv});
            chk($sformatf("vec%0d_in_rdy", i), {31'b0, in_rdy}, 32'h1);
            if (tv[i].xv) begin
                chk($sformatf("vec%0d_out_lanes", i), out_lanes, tv[i].xl);
                chk($sformatf("vec%0d_out_lane_en", i), {28'b0, out_lane_en}, {28'b0, tv[i].xe});
            end
        end
        cyc(2'd2, 0, 8'h00, 0, 1);

        // Backpressure: first word held, second parked, input stalled
        for (int i = 0; i < 8; i++) begin
            cyc(2'd2, 1, 8'hE0 + 8'(i), 0, 0);
            if (i >= 3) begin
                chk($sformatf("bp_hold_vld_%0d", i), {31'b0, out_vld}, 32'h1);
                chk($sformatf("bp_hold_lanes_%0d", i), out_lanes, 32'hE3E2E1E0);
                chk($sformatf("bp_hold_en_%0d", i), {28'b0, out_lane_en}, 32'hF);
            end
            chk($sformatf("bp_in_rdy_%0d", i), {31'b0, in_rdy}, (i == 7) ? 32'h0 : 32'h1);
        end
        cyc(2'd2, 1, 8'hEF, 0, 0);
        chk("bp_stall_lanes", out_lanes, 32'hE3E2E1E0);
        chk("bp_stall_in_rdy", {31'b0, in_rdy}, 32'h0);
        cyc(2'd2, 0, 8'h00, 0, 1);
        chk("bp_drain1_vld", {31'b0, out_vld}, 32'h1);
        chk("bp_drain1_lanes", out_lanes, 32'hE7E6E5E4);
        chk("bp_drain1_in_rdy", {31'b0, in_rdy}, 32'h1);
        cyc(2'd2, 0, 8'h00, 0, 1);
        chk("bp_drain2_vld", {31'b0, out_vld}, 32'h0);

        // Reset mid-stripe with a held word pending
        cyc(2'd2, 1, 8'h21, 0, 0);
        cyc(2'd2, 1, 8'h22, 0, 0);
        cyc(2'd2, 1, 8'h23, 0, 0);
        cyc(2'd2, 1, 8'h24, 0, 0);
        chk("mr_held_vld", {31'b0, out_vld}, 32'h1);
        cyc(2'd2, 1, 8'hF1, 0, 0);
        cyc(2'd2, 1, 8'hF2, 0, 0);
        cyc(2'd2, 1, 8'hF3, 0, 0);
        @(negedge CLK);
        in_vld = 1'b0; out_rdy = 1'b1;
        reset = 1'b0;
        #1;
        chk("mr_out_vld", {31'b0, out_vld}, 32'h0);
        chk("mr_out_lanes", out_lanes, 32'h7C7C7C7C);
        chk("mr_out_lane_en", {28'b0, out_lane_en}, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(2'd2, 1, 8'h11 + 8'(i), 0, 1);
            chk($sformatf("mr_post_vld_%0d", i), {31'b0, out_vld}, (i == 3) ? 32'h1 : 32'h0);
        end
        chk("mr_post_lanes", out_lanes, 32'h14131211);
        chk("mr_post_en", {28'b0, out_lane_en}, 32'hF);
        cyc(2'd2, 0, 8'h00, 0, 1);
        chk("mr_post_single", {31'b0, out_vld}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
